// File: rtl/feature_collector.sv
// Feature collector: filters flagged pixels, enforces a per-frame cap, buffers
// accepted feature words in a show-ahead FIFO and reports per-frame statistics.
module feature_collector #(
  parameter int COL        = 640,
  parameter int ROW        = 480,
  parameter int DES_WIDTH  = 148,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_FEAT   = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic                 feature_flag,
  input  logic [DES_WIDTH-1:0] des_coor,
  output logic [DES_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 frame_done,
  output logic [15:0]          feat_count,
  output logic [15:0]          drop_count,
  output logic                 overflow
);

  localparam int NPIX  = COL * ROW;
  localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int OW    = ADDR_WIDTH + 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PW-1:0]         pix_cnt;
  logic [15:0]           frame_feat;
  logic [15:0]           frame_drop;
  logic [OW-1:0]         occ;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DES_WIDTH-1:0]  mem [DEPTH];
  logic                  vld_p1;

  logic                  last_p0;
  logic                  cand_p0;
  logic                  full_p0;
  logic                  cap_ok_p0;
  logic                  wr_en_p0;
  logic                  drop_p0;
  logic                  rd_en_p1;
  logic [OW-1:0]         ram_cnt;
  logic                  load_p1;
  logic [15:0]           feat_nxt;
  logic [15:0]           drop_nxt;

  // Stage p0: candidate decision against the pre-edge FIFO and cap state
  always_comb begin
    last_p0   = din_valid && (pix_cnt == PW'(NPIX - 1));
    cand_p0   = din_valid && feature_flag;
    full_p0   = (occ == OW'(DEPTH));
    cap_ok_p0 = (frame_feat < 16'(MAX_FEAT));
    wr_en_p0  = cand_p0 && !full_p0 && cap_ok_p0;
    drop_p0   = cand_p0 && !wr_en_p0;
    feat_nxt  = frame_feat + 16'(wr_en_p0);
    drop_nxt  = drop_p0 ? sat_inc(frame_drop) : frame_drop;
  end

  // Stage p1: output register fed by a registered RAM read
  always_comb begin
    rd_en_p1 = vld_p1 && dout_ready;
    ram_cnt  = occ - OW'(vld_p1);
    load_p1  = (ram_cnt != '0) && (!vld_p1 || dout_ready);
  end

  always_ff @(posedge clk) begin
    if (wr_en_p0) begin
      mem[wr_ptr] <= des_coor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (din_valid) begin
      pix_cnt <= last_p0 ? '0 : pix_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      occ <= occ + OW'(wr_en_p0) - OW'(rd_en_p1);
      if (wr_en_p0) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (load_p1) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      dout   <= '0;
    end else if (load_p1) begin
      vld_p1 <= 1'b1;
      dout   <= mem[rd_ptr];
    end else if (rd_en_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  assign dout_valid = vld_p1;

  // Frame statistics: running counts fold into the reported counts on the last pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_feat <= '0;
      frame_drop <= '0;
      feat_count <= '0;
      drop_count <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= last_p0;
      if (last_p0) begin
        feat_count <= feat_nxt;
        drop_count <= drop_nxt;
        frame_feat <= '0;
        frame_drop <= '0;
      end else begin
        frame_feat <= feat_nxt;
        frame_drop <= drop_nxt;
      end
      if (cand_p0 && full_p0) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_feature_collector.sv
// Scoreboard bench for feature_collector on a small 8x4 frame with a 4-entry FIFO.
module tb_feature_collector;

  localparam int COL  = 8;
  localparam int ROW  = 4;
  localparam int NPIX = COL * ROW;
  localparam int DW   = 148;
  localparam int AW   = 2;
  localparam int MF   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_valid = 1'b0;
  logic          feature_flag = 1'b0;
  logic [DW-1:0] des_coor = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          frame_done;
  logic [15:0]   feat_count;
  logic [15:0]   drop_count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int pix      = 0;
  logic [DW-1:0] sb[$];

  feature_collector #(
    .COL(COL), .ROW(ROW), .DES_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_FEAT(MF)
  ) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .feature_flag(feature_flag),
    .des_coor(des_coor), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .frame_done(frame_done), .feat_count(feat_count),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int p);
    return {10'(p % COL), 10'(p / COL), {3{32'hA5C3_0F1E}}, 32'(p * 13 + 7)};
  endfunction

  // One clock: pops the scoreboard on a transfer, then steps past the edge.
  task automatic cyc();
    logic [DW-1:0] exp;
    if (dout_valid && dout_ready && !rst) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got word %h, required no output", dout);
      end else begin
        exp = sb.pop_front();
        if (dout !== exp) begin
          n_fail++;
          $display("FAIL sb_data: got %h required %h", dout, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit flag, input bit push);
    din_valid    = 1'b1;
    feature_flag = flag;
    des_coor     = word(pix);
    if (push) sb.push_back(word(pix));
    cyc();
    din_valid    = 1'b0;
    feature_flag = 1'b0;
    pix          = (pix + 1) % NPIX;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    pix = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if ({dout_valid, frame_done, overflow, feat_count, drop_count, dout} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: cycle %0d got valid=%b done=%b ovf=%b feat=%0d drop=%0d, required all 0",
                 i, dout_valid, frame_done, overflow, feat_count, drop_count);
      end
    end
    rst = 1'b0;
    pix = 0;
    sb.delete();
    for (int p = 0; p < 5; p++) send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency: got dout_valid=%b required 0", dout_valid);
    end
    send(1'b0, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== word(5)) begin
      n_fail++; $display("FAIL basic_out: got valid=%b dout=%h required 1 %h", dout_valid, dout, word(5));
    end
    send(1'b0, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_fall: got dout_valid=%b required 0", dout_valid);
    end
    while (pix != NPIX - 1) send(1'b0, 1'b0);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_done: got %b required 0", frame_done);
    end
    send(1'b0, 1'b0);
    n_checks++;
    if (frame_done !== 1'b1 || feat_count !== 16'd1 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL basic_frame: got done=%b feat=%0d drop=%0d required 1 1 0",
                         frame_done, feat_count, drop_count);
    end
    idle(1);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: got %b required 0", frame_done);
    end
  endtask

  task automatic test_fifo_full();
    dout_ready = 1'b0;
    for (int p = 0; p < 4; p++) send(1'b1, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_no_ovf: got %b required 0", overflow);
    end
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL full_ovf: got %b required 1", overflow);
    end
    while (pix != 0) begin
      send(1'b0, 1'b0);
      if (pix == 15) begin
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== word(0)) begin
          n_fail++; $display("FAIL full_hold: got valid=%b dout=%h required 1 %h", dout_valid, dout, word(0));
        end
      end
    end
    n_checks++;
    if (frame_done !== 1'b1 || feat_count !== 16'd4 || drop_count !== 16'd2) begin
      n_fail++; $display("FAIL full_frame: got done=%b feat=%0d drop=%0d required 1 4 2",
                         frame_done, feat_count, drop_count);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dout_valid !== 1'b1) begin
        n_fail++; $display("FAIL full_drain: cycle %0d got dout_valid=%b required 1", i, dout_valid);
      end
      cyc();
    end
    n_checks++;
    if (dout_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL full_empty: got valid=%b pending=%0d required 0 0", dout_valid, sb.size());
    end
  endtask

  task automatic test_cap();
    do_reset();
    dout_ready = 1'b1;
    for (int p = 0; p < NPIX; p++) send(1'b1, p < MF);
    n_checks++;
    if (frame_done !== 1'b1 || feat_count !== 16'd6 || drop_count !== 16'd26 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL cap_frame: got done=%b feat=%0d drop=%0d ovf=%b required 1 6 26 0",
                         frame_done, feat_count, drop_count, overflow);
    end
    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL cap_drain: got %0d words pending required 0", sb.size());
    end
  endtask

  task automatic test_boundary();
    dout_ready = 1'b1;
    while (pix != NPIX - 1) send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    n_checks++;
    if (frame_done !== 1'b1 || feat_count !== 16'd1 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL bound_frame0: got done=%b feat=%0d drop=%0d required 1 1 0",
                         frame_done, feat_count, drop_count);
    end
    send(1'b1, 1'b1);
    while (pix != 0) send(1'b0, 1'b0);
    n_checks++;
    if (frame_done !== 1'b1 || feat_count !== 16'd1 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL bound_frame1: got done=%b feat=%0d drop=%0d required 1 1 0",
                         frame_done, feat_count, drop_count);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL bound_drain: got %0d words pending required 0", sb.size());
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    dout_ready = 1'b0;
    for (int p = 0; p < 4; p++) send(1'b1, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rw_fill: got valid=%b ovf=%b required 1 0", dout_valid, overflow);
    end
    dout_ready = 1'b1;
    send(1'b1, 1'b0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL rw_ovf: got %b required 1", overflow);
    end
    dout_ready = 1'b0;
    idle(1);
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== word(1)) begin
      n_fail++; $display("FAIL rw_next: got valid=%b dout=%h required 1 %h", dout_valid, dout, word(1));
    end
    dout_ready = 1'b1;
    idle(4);
    n_checks++;
    if (dout_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL rw_occ: got valid=%b pending=%0d required 0 0", dout_valid, sb.size());
    end
    while (pix != 0) send(1'b0, 1'b0);
    n_checks++;
    if (feat_count !== 16'd4 || drop_count !== 16'd1) begin
      n_fail++; $display("FAIL rw_frame: got feat=%0d drop=%0d required 4 1", feat_count, drop_count);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    dout_ready = 1'b0;
    for (int p = 0; p < 3; p++) send(1'b1, 1'b0);
    while (pix != 17) send(1'b0, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_buffered: got dout_valid=%b required 1", dout_valid);
    end
    rst = 1'b1;
    din_valid = 1'b1;
    des_coor = word(17);
    cyc();
    rst = 1'b0;
    din_valid = 1'b0;
    n_checks++;
    if ({dout_valid, frame_done, overflow, feat_count, drop_count} !== '0) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b done=%b ovf=%b feat=%0d drop=%0d required all 0",
                         dout_valid, frame_done, overflow, feat_count, drop_count);
    end
    pix = 0;
    dout_ready = 1'b1;
    for (int p = 0; p < NPIX - 1; p++) send(p == 2, p == 2);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_early_done: got %b required 0", frame_done);
    end
    send(1'b0, 1'b0);
    n_checks++;
    if (frame_done !== 1'b1 || feat_count !== 16'd1 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_frame: got done=%b feat=%0d drop=%0d required 1 1 0",
                         frame_done, feat_count, drop_count);
    end
    idle(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL mid_drain: got %0d words pending required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_fifo_full();
    test_cap();
    test_boundary();
    test_full_rw();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
